// File: rtl/quant_stream.sv
// Streaming DCT quantizer: multiplies each coefficient by a per-index reciprocal from one of
// N_TABLES runtime-loaded tables, rounds half away from zero, saturates symmetrically.
module quant_stream #(
    parameter int DATA_W   = 12,
    parameter int OUT_W    = 11,
    parameter int RECIP_W  = 16,
    parameter int N_TABLES = 2,
    localparam int SEL_W   = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         tbl_sel,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sob,
    output logic                     out_eob,
    input  logic                     tbl_we,
    input  logic [SEL_W-1:0]         tbl_wsel,
    input  logic [5:0]               tbl_waddr,
    input  logic [RECIP_W-1:0]       tbl_wdata
);
    localparam int MAG_W = DATA_W + RECIP_W;
    localparam int Q_W   = DATA_W + 1;
    localparam logic [MAG_W:0]   HALF    = {{(MAG_W-RECIP_W+1){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
    localparam logic [Q_W-1:0]   SAT_MAX = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_OUT = {1'b0, {(OUT_W-1){1'b1}}};

    logic [RECIP_W-1:0] tbl_q [N_TABLES][64];

    logic [5:0]        idx_q;
    logic [SEL_W-1:0]  cur_tbl_q;
    logic              s1_vld_q, s1_neg_q, s1_sob_q, s1_eob_q;
    logic [MAG_W-1:0]  s1_mag_q;
    logic              out_valid_q, out_sob_q, out_eob_q;
    logic [OUT_W-1:0]  out_data_q;

    logic              adv, accept;
    logic [SEL_W-1:0]  sel_in, rd_tbl;
    logic [RECIP_W-1:0] recip;
    logic [DATA_W:0]   ext, abs_v;
    logic [MAG_W-1:0]  mag_d;
    logic [MAG_W:0]    rnd;
    logic [Q_W-1:0]    q_full;
    logic [OUT_W-1:0]  sat_mag, data_d;
    logic              unused_rnd_lsbs;

    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // The index-0 beat must already use the table it selects, so bypass cur_tbl_q there.
    assign sel_in = (32'(tbl_sel) < N_TABLES) ? tbl_sel : '0;
    assign rd_tbl = (idx_q == 6'd0) ? sel_in : cur_tbl_q;
    assign recip  = tbl_q[rd_tbl][idx_q];

    // Magnitude at DATA_W+1 bits so the most negative input has a representable magnitude.
    assign ext   = {in_data[DATA_W-1], in_data};
    assign abs_v = ext[DATA_W] ? -ext : ext;
    assign mag_d = {{(RECIP_W-1){1'b0}}, abs_v} * {{DATA_W{1'b0}}, recip};

    assign rnd             = {1'b0, s1_mag_q} + HALF;
    assign q_full          = rnd[MAG_W:RECIP_W];
    assign unused_rnd_lsbs = ^rnd[RECIP_W-1:0];
    assign sat_mag         = (q_full > SAT_MAX) ? SAT_OUT : q_full[OUT_W-1:0];
    assign data_d          = s1_neg_q ? -sat_mag : sat_mag;

    // Table storage is deliberately outside reset; a same-cycle read sees the old entry.
    always_ff @(posedge Clock) begin
        if (tbl_we && (32'(tbl_wsel) < N_TABLES))
            tbl_q[tbl_wsel][tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            idx_q       <= '0;
            cur_tbl_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_sob_q    <= 1'b0;
            s1_eob_q    <= 1'b0;
            s1_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            s1_vld_q    <= accept;
            out_valid_q <= s1_vld_q;
            if (accept) begin
                idx_q    <= idx_q + 6'd1;
                if (idx_q == 6'd0)
                    cur_tbl_q <= sel_in;
                s1_mag_q <= mag_d;
                s1_neg_q <= in_data[DATA_W-1];
                s1_sob_q <= (idx_q == 6'd0);
                s1_eob_q <= (idx_q == 6'd63);
            end
            if (s1_vld_q) begin
                out_data_q <= data_d;
                out_sob_q  <= s1_sob_q;
                out_eob_q  <= s1_eob_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sob   = out_sob_q;
    assign out_eob   = out_eob_q;
endmodule

// File: doc/quant_stream.md
# quant_stream

Streaming quantizer for the DCT stage of the image pipeline. It accepts signed DCT coefficients in 8x8 block order (64 per block) and divides each one by its quantization step, implemented as multiplication by a stored reciprocal. It rounds half away from zero, saturates, and emits the results over a valid/ready handshake. It holds `N_TABLES` runtime-loadable reciprocal tables, for example luma and chroma, and selects one per block.

## Interface
Parameters:
- `DATA_W`, 12: signed input coefficient width.
- `OUT_W`, 11: signed output width; symmetric saturation.
- `RECIP_W`, 16: unsigned reciprocal width; entry = round(2^RECIP_W / q).
- `N_TABLES`, 2: number of 64-entry reciprocal tables.

Ports:
- `Clock`, in, 1: single clock; all logic on its rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `in_data`, in, DATA_W: signed coefficient.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block accepts a beat when `in_valid && in_ready`.
- `tbl_sel`, in, clog2(N_TABLES) (min 1): table for the block; sampled on index-0 beats only.
- `out_data`, out, OUT_W: signed quantized value.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts.
- `out_sob`, out, 1: beat is index 0 of a block.
- `out_eob`, out, 1: beat is index 63 of a block.
- `tbl_we`, in, 1: table write strobe.
- `tbl_wsel`, in, clog2(N_TABLES): table to write.
- `tbl_waddr`, in, 6: entry index (zigzag-free, raster order).
- `tbl_wdata`, in, RECIP_W: reciprocal value.

## Operation
- Index counter `idx` (6 bit) advances on each accepted input and wraps 63 -> 0. There is no explicit start-of-block input; block framing is purely by count.
- On an accepted beat with `idx == 0`, `tbl_sel` is latched as `cur_tbl`. That beat and the following 63 use `cur_tbl`. Values of `tbl_sel` on other beats are ignored. A `tbl_sel` value >= N_TABLES selects table 0.
- Stage 1 (registered):
  - read `recip = T[cur_tbl][idx]`;
  - form `mag = |in_data| * recip`, width DATA_W+RECIP_W;
  - keep the sign, and carry `sob = (idx==0)` and `eob = (idx==63)`.
- Stage 2 (registered):
  - `q = (mag + 2^(RECIP_W-1)) >> RECIP_W`;
  - saturate `q` to 2^(OUT_W-1)-1;
  - apply the sign. The output range is therefore [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)], and negative zero is emitted as 0.
- Input -2^(DATA_W-1) is handled: its magnitude is computed at DATA_W+1 bits.
- A reciprocal entry of 0 yields output 0.
- Table write: on `tbl_we`, `T[tbl_wsel][tbl_waddr] <= tbl_wdata`.
  - If a read hits the same address in the same cycle, it returns the old value.
  - The new value is visible from the next cycle.
  - Writes are accepted regardless of stream state and reset.
  - Writes with `tbl_wsel` >= N_TABLES are ignored.
- Tables are not initialised by `Reset`. Contents are undefined until written.

## Timing
- Latency: an accepted input appears on `out_*` exactly 2 cycles later when there is no back-pressure.
- Pipeline enable `adv = !(out_valid && !out_ready)`. Both stages advance only when `adv`. `in_ready = adv`, which is combinational from `out_valid` and `out_ready`.
- Throughput: 1 beat/cycle sustained with `out_ready` held high.
- Bubbles (`in_valid` low) propagate as `out_valid` low. Bubbles are not squeezed out.
- While `out_valid && !out_ready`:
  - `out_data`, `out_sob` and `out_eob` hold stable;
  - `idx` and `cur_tbl` do not change;
  - no input is accepted.
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_sob = 0`, `out_eob = 0`;
  - `idx = 0`, `cur_tbl = 0`;
  - both stage valids = 0;
  - `in_ready = 1` in the cycle after reset.
- Reset mid-block: in-flight beats are discarded, with no partial output. The next accepted beat is index 0.
- A simultaneous accept of an index-63 beat and an index-0 beat is not possible, because there is one input per cycle. The wrap is seamless: the next block's index 0 may be accepted in the cycle after index 63.

## Test plan
- Basic rounding:
  - T0 all entries 4096 (q=16); feed 64 beats of 100 -> 64 outputs of 6;
  - `out_sob` on beat 0 only, `out_eob` on beat 63 only;
  - latency 2 cycles.
- Half-away and sign: T0 entries 4096, inputs -24, 24, -8, 0 -> -2, 2, -1, 0.
- Saturation: T1 entry 65535 (q~1), `tbl_sel=1` at index 0, input 2047 -> 1023; input -2048 -> -1023.
- Back-pressure:
  - random `out_ready` (~50%) over 3 blocks with random `in_valid`;
  - the output sequence equals the golden model;
  - `out_*` stable while stalled;
  - exactly 192 beats emitted.
- Table switching and write hazard:
  - `tbl_sel` toggles between 0 and 1 at index 0 and at index 5; only the index-0 value takes effect for the whole block;
  - a write to `T[0][3]` in the same cycle that index 3 is read uses the old value, and the next block uses the new value.
- Reset mid-block: assert `Reset` after 30 beats with 2 in flight -> no output from those beats; the next input is tagged `out_sob=1`.
